// File: rtl/random_range_sampler_pkg.sv
// rtl/random_range_sampler_pkg.sv - shared state encodings and defaults for the range sampler
package random_range_sampler_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int REJECT_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MASK   = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

endpackage

// File: rtl/random_sample_fifo.sv
// rtl/random_sample_fifo.sv - synchronous Width x Depth FIFO with push/pop/flush
module random_sample_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // Head is forced to zero when empty so the output never shows stale entries
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because Depth is a power of two; flush beats push/pop
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/random_range_sampler.sv
// rtl/random_range_sampler.sv - mask-and-reject uniform sampler in [0,bound); optional RANDOM_SAMPLER_STATS_EN adds reject_cnt
module random_range_sampler
  import random_range_sampler_pkg::*;
#(
  parameter int Width = DEFAULT_WIDTH,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] random_in,
  output logic             rng_ce,
  input  logic [Width-1:0] bound,
  input  logic             bound_load,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef RANDOM_SAMPLER_STATS_EN
  ,
  output logic [REJECT_CNT_W-1:0] reject_cnt
`endif
);

  state_e           state_q, state_d;
  logic [Width-1:0] bound_q;
  logic [Width-1:0] mask_q;
  logic [Width-1:0] cand;
  logic             accept;
  logic             fifo_full, fifo_empty;

  // Smallest all-ones mask covering b-1: OR-smear the top set bit downwards
  function automatic logic [Width-1:0] mask_for(input logic [Width-1:0] b);
    logic [Width-1:0] m;
    m = b - Width'(1);
    for (int s = 1; s < Width; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  assign cand   = random_in & mask_q;
  assign accept = rng_ce & (cand < bound_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state and generator enable; a bound load overrides whatever is in progress
  always_comb begin
    state_d = state_q;
    rng_ce  = 1'b0;
    case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_MASK:   state_d = ST_SAMPLE;
      ST_SAMPLE: rng_ce  = ~fifo_full;
      default:   state_d = ST_IDLE;
    endcase
    if (bound_load) state_d = (bound == '0) ? ST_IDLE : ST_MASK;
  end

  // Bound capture and mask derivation (mask is settled during the MASK cycle)
  always_ff @(posedge clk) begin
    if (!rst) begin
      bound_q <= '0;
      mask_q  <= '0;
    end else begin
      if (bound_load)          bound_q <= bound;
      if (state_q == ST_MASK)  mask_q  <= mask_for(bound_q);
    end
  end

`ifdef RANDOM_SAMPLER_STATS_EN
  logic [REJECT_CNT_W-1:0] reject_cnt_q;
  logic                    reject;

  assign reject     = rng_ce & ~accept;
  assign reject_cnt = reject_cnt_q;

  // Saturating rejected-draw counter, restarted with every new bound
  always_ff @(posedge clk) begin
    if (!rst || bound_load) reject_cnt_q <= '0;
    else if (reject && reject_cnt_q != '1) reject_cnt_q <= reject_cnt_q + 1'b1;
  end
`endif

  random_sample_fifo #(
    .Width (Width),
    .Depth (Depth)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bound_load),
    .push_i      (accept),
    .push_data_i (cand),
    .pop_i       (out_ready),
    .head_o      (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_random_range_sampler.sv
// tb/tb_random_range_sampler.sv - self-checking bench for random_range_sampler
module tb_random_range_sampler;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] random_in;
  logic         rng_ce;
  logic [W-1:0] bound;
  logic         bound_load;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
`ifdef RANDOM_SAMPLER_STATS_EN
  logic [15:0]  reject_cnt;
`endif

  always #5 clk = ~clk;

  random_range_sampler #(.Width(W), .Depth(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .random_in  (random_in),
    .rng_ce     (rng_ce),
    .bound      (bound),
    .bound_load (bound_load),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef RANDOM_SAMPLER_STATS_EN
    ,
    .reject_cnt (reject_cnt)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int unsigned exp_q[$];
  int unsigned src_q[$];
  longint      bound_m = 0;
  int          phase = 0;
  int          rej_m = 0;
  int          draws = 0;
  bit          hold = 0;
  bit          sweep = 0;
  int          hist[37];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint mask_of(input longint b);
    longint m = 0;
    while (m < b - 1) m = m * 2 + 1;
    return m;
  endfunction

  task automatic tick();
    bit     ce_exp;
    longint cand;
    @(negedge clk);
    ce_exp = 1'b0;
    if (rst) begin
      ce_exp = (phase == 2) && (exp_q.size() < D);
      chk("rng_ce", rng_ce, ce_exp);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
`ifdef RANDOM_SAMPLER_STATS_EN
      chk("reject_cnt", reject_cnt, rej_m);
`endif
      if (bound_load) begin
        exp_q.delete();
        bound_m = bound;
        phase = (bound == 0) ? 0 : 1;
        rej_m = 0;
      end else begin
        if (exp_q.size() != 0 && out_ready) begin
          chk("range", out_data < bound_m, 1'b1);
          if (sweep && out_data < 37) hist[out_data]++;
          void'(exp_q.pop_front());
        end
        if (ce_exp) begin
          cand = random_in & mask_of(bound_m);
          draws++;
          if (cand < bound_m) exp_q.push_back(int'(cand));
          else if (rej_m < 65535) rej_m++;
        end
        if (phase == 1) phase = 2;
      end
    end
    @(posedge clk);
    #1;
    if (ce_exp) begin
      if (src_q.size() != 0) random_in = src_q.pop_front();
      else if (!hold)        random_in = $urandom;
    end
  endtask

  task automatic load(input logic [W-1:0] b);
    bound = b;
    bound_load = 1'b1;
    tick();
    bound_load = 1'b0;
  endtask

  initial begin
    int     cyc;
    real    chi2, e;
    int     total;

    // Reset
    rst = 1'b0; random_in = 32'hFFFFFFFF; bound = '0; bound_load = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_rng_ce", rng_ce, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
`ifdef RANDOM_SAMPLER_STATS_EN
    chk("rst_reject_cnt", reject_cnt, 16'h0);
`endif
    rst = 1'b1;
    tick();

    // bound=10: 0xF rejected, 0x3 accepted, 0x...A rejected
    random_in = 32'h0000000F;
    src_q = '{32'h00000003, 32'h1234567A};
    load(32'd10);
    tick(); tick(); tick(); tick();
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_data", out_data, 32'd3);
`ifdef RANDOM_SAMPLER_STATS_EN
    chk("t2_reject_cnt", reject_cnt, 16'd2);
`endif
    out_ready = 1'b1;
    repeat (10) tick();

    // bound=8, constant 5, back-pressure until full then drain
    out_ready = 1'b0;
    hold = 1'b1;
    random_in = 32'h5;
    load(32'd8);
    repeat (10) tick();
    chk("t3_full_ce", rng_ce, 1'b0);
    chk("t3_full_data", out_data, 32'd5);
    out_ready = 1'b1;
    repeat (8) tick();
    hold = 1'b0;

    // bound=1 then bound=0
    load(32'd1);
    for (int i = 0; i < 12; i++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    load(32'd0);
    tick();
    chk("t4_idle_ce", rng_ce, 1'b0);
    chk("t4_idle_valid", out_valid, 1'b0);

    // Mid-operation reload with two entries queued
    out_ready = 1'b0;
    load(32'd100);
    for (int i = 0; i < 50 && exp_q.size() != 2; i++) tick();
    chk("t5_fill", exp_q.size(), 2);
    bound = 32'd3;
    bound_load = 1'b1;
    tick();
    bound_load = 1'b0;
    chk("t5_flushed", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (20) tick();

    // Random sweep, bound=37
    load(32'd37);
    foreach (hist[i]) hist[i] = 0;
    sweep = 1'b1;
    draws = 0;
    cyc = 0;
    while (draws < 10000 && cyc < 40000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    chk("t6_budget", draws >= 10000, 1'b1);
    out_ready = 1'b1;
    repeat (8) tick();
    sweep = 1'b0;
    total = 0;
    foreach (hist[i]) total += hist[i];
    e = real'(total) / 37.0;
    chi2 = 0.0;
    foreach (hist[i]) chi2 += (real'(hist[i]) - e) * (real'(hist[i]) - e) / e;
    chk("t6_count", total > 5000, 1'b1);
    chk("t6_chi2", chi2 < 75.0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
